// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the bit-serial tx/rx pair.
// Defining PISO_TX_PARITY_EN appends one even-parity bit to every frame.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

`ifdef PISO_TX_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int nbits(input int width, input bit parity);
    return parity ? width + 1 : width;
  endfunction

endpackage

// File: rtl/piso_bit_cnt.sv
// Modulo-N bit position counter; clear wins over increment, reset wins over enable.
// tc flags the last position of a frame (count == N-1).
module piso_bit_cnt
  import piso_pkg::*;
#(
  parameter int N  = 8,
  parameter int CW = cnt_w(N)
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      if (clr) begin
        cnt_d = '0;
      end else if (inc) begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == LAST);

endmodule

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter: first bit one cycle after accept, din_ready during the last bit.
// With PISO_TX_PARITY_EN the even-parity bit rides in the shift register as the final bit.
module piso_tx
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             Rs,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_first,
  output logic             busy
);

  localparam int NBITS = nbits(WIDTH, PARITY_EN);
  localparam int CW    = cnt_w(NBITS);

  state_e           state_q, state_d;
  logic [NBITS-1:0] shreg_q, shreg_d;
  logic [NBITS-1:0] load_word, shifted;
  logic             sout_q, sout_d;
  logic             sout_valid_q, sout_valid_d;
  logic             sout_first_q, sout_first_d;
  logic             busy_q, busy_d;
  logic             cnt_tc, accept, in_shift;

  function automatic logic head(input logic [NBITS-1:0] w);
    return MSB_FIRST ? w[NBITS-1] : w[0];
  endfunction

`ifdef PISO_TX_PARITY_EN
  // Parity sits on the trailing end so it falls out after the data bits.
  assign load_word = MSB_FIRST ? {din, ^din} : {^din, din};
`else
  assign load_word = din;
`endif

  assign shifted   = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
  assign in_shift  = (state_q == SHIFT);
  assign din_ready = en & (~in_shift | cnt_tc);
  assign accept    = din_valid & din_ready;

  piso_bit_cnt #(
    .N (NBITS),
    .CW(CW)
  ) u_bit_cnt (
    .clk(clk),
    .rst(Rs),
    .en (en),
    .clr(accept),
    .inc(in_shift),
    .tc (cnt_tc)
  );

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    sout_d       = sout_q;
    sout_valid_d = sout_valid_q;
    sout_first_d = sout_first_q;
    busy_d       = busy_q;
    if (accept) begin
      state_d      = SHIFT;
      shreg_d      = load_word;
      sout_d       = head(load_word);
      sout_valid_d = 1'b1;
      sout_first_d = 1'b1;
      busy_d       = 1'b1;
    end else if (en && in_shift) begin
      if (cnt_tc) begin
        state_d      = IDLE;
        shreg_d      = '0;
        sout_d       = 1'b0;
        sout_valid_d = 1'b0;
        sout_first_d = 1'b0;
        busy_d       = 1'b0;
      end else begin
        shreg_d      = shifted;
        sout_d       = head(shifted);
        sout_valid_d = 1'b1;
        sout_first_d = 1'b0;
        busy_d       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (Rs) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      sout_first_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      sout_first_q <= sout_first_d;
      busy_q       <= busy_d;
    end
  end

  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign sout_first = sout_first_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_piso_tx.sv
// Drives an MSB-first and an LSB-first piso_tx with the same stimulus and
// checks both every cycle against a word/bit-position model.
module tb_piso_tx;

  localparam int W = 8;
`ifdef PISO_TX_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic         clk = 1'b0;
  logic         rs, en, din_valid;
  logic [W-1:0] din;
  logic rdy_m, sout_m, sv_m, sf_m, busy_m;
  logic rdy_l, sout_l, sv_l, sf_l, busy_l;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_on      = 1'b0;

  // Model: the captured word and which bit of the frame is on the line (-1 = idle).
  int           m_idx  = -1;
  logic [W-1:0] m_word = '0;

  always #5 clk = ~clk;

  piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .Rs(rs), .en(en), .din(din), .din_valid(din_valid),
    .din_ready(rdy_m), .sout(sout_m), .sout_valid(sv_m), .sout_first(sf_m), .busy(busy_m)
  );

  piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .Rs(rs), .en(en), .din(din), .din_valid(din_valid),
    .din_ready(rdy_l), .sout(sout_l), .sout_valid(sv_l), .sout_first(sf_l), .busy(busy_l)
  );

  function automatic logic exp_bit(input logic [W-1:0] w, input int idx, input bit msb);
    if (idx >= W) return ^w;
    return msb ? w[W-1-idx] : w[idx];
  endfunction

  function automatic logic model_ready();
    return en && (m_idx < 0 || m_idx == NB - 1);
  endfunction

  task automatic check1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rs) begin
      m_idx = -1;
    end else if (en) begin
      if (din_valid && (m_idx < 0 || m_idx == NB - 1)) begin
        m_word = din;
        m_idx  = 0;
      end else if (m_idx >= 0) begin
        m_idx = (m_idx == NB - 1) ? -1 : m_idx + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check1("din_ready_msb", rdy_m, model_ready());
      check1("din_ready_lsb", rdy_l, model_ready());
      check1("sout_valid_msb", sv_m, m_idx >= 0);
      check1("sout_valid_lsb", sv_l, m_idx >= 0);
      check1("sout_first_msb", sf_m, m_idx == 0);
      check1("sout_first_lsb", sf_l, m_idx == 0);
      check1("busy_msb", busy_m, m_idx >= 0);
      check1("busy_lsb", busy_l, m_idx >= 0);
      check1("sout_msb", sout_m, (m_idx >= 0) ? exp_bit(m_word, m_idx, 1'b1) : 1'b0);
      check1("sout_lsb", sout_l, (m_idx >= 0) ? exp_bit(m_word, m_idx, 1'b0) : 1'b0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepts one word from idle and samples its data bits; returns aligned on the bit after the data.
  task automatic run_frame(input logic [W-1:0] word, output logic [31:0] s_m, output logic [31:0] s_l);
    s_m       = '0;
    s_l       = '0;
    din       = word;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    for (int i = 0; i < W; i++) begin
      s_m = {s_m[30:0], sout_m};
      s_l = {s_l[30:0], sout_l};
      tick();
    end
  endtask

  task automatic end_of_frame(input string name, input logic par);
`ifdef PISO_TX_PARITY_EN
    check1({name, "_parity"}, sout_m, par);
    tick();
`else
    if (par !== 1'bx) vectors = vectors + 0;
`endif
    check1({name, "_idle_valid"}, sv_m, 1'b0);
    check1({name, "_idle_busy"}, busy_m, 1'b0);
    tick();
  endtask

  logic [31:0] s_m, s_l;
  bit          hold;

  initial begin
    rs = 1'b1; en = 1'b0; din_valid = 1'b0; din = '0;
    tick();
    chk_on = 1'b1;
    check1("reset_valid", sv_m, 1'b0);
    check1("reset_sout", sout_m, 1'b0);
    rs = 1'b0; en = 1'b1;
    tick();

    run_frame(8'hA5, s_m, s_l);
    check32("a5_msb_stream", s_m, 32'hA5);
    check32("a5_lsb_stream", s_l, 32'hA5);
    end_of_frame("a5", 1'b0);

    run_frame(8'h01, s_m, s_l);
    check32("01_msb_stream", s_m, 32'h01);
    check32("01_lsb_stream", s_l, 32'h80);
    end_of_frame("01", 1'b1);

    run_frame(8'h07, s_m, s_l);
    check32("07_msb_stream", s_m, 32'h07);
    check32("07_lsb_stream", s_l, 32'hE0);
    end_of_frame("07", 1'b1);

    // Back-to-back: second word held valid until the last-bit handover.
    s_m = '0;
    din = 8'hA5; din_valid = 1'b1;
    tick();
    din = 8'h3C;
    for (int i = 0; i < 2 * NB; i++) begin
      if (i == NB) begin
        check1("b2b_second_first", sf_m, 1'b1);
        din_valid = 1'b0;
      end
      s_m = {s_m[30:0], sout_m};
      tick();
    end
`ifdef PISO_TX_PARITY_EN
    check32("b2b_stream", s_m, 32'h29478);
`else
    check32("b2b_stream", s_m, 32'hA53C);
`endif
    check1("b2b_idle_valid", sv_m, 1'b0);
    tick();

    // Enable stall on bit 2 for two disabled edges.
    s_m = '0;
    din = 8'hA5; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    for (int i = 0; i < W; i++) begin
      s_m = {s_m[30:0], sout_m};
      if (i == 2) begin
        en = 1'b0;
        tick();
        check1("stall_hold_1", sout_m, 1'b1);
        tick();
        check1("stall_hold_2", sout_m, 1'b1);
        en = 1'b1;
      end
      tick();
    end
    check32("stall_stream", s_m, 32'hA5);
    end_of_frame("stall", 1'b0);

    // Reset mid-frame, then a fresh word.
    din = 8'hA5; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    tick(); tick(); tick();
    rs = 1'b1;
    tick();
    rs = 1'b0;
    check1("abort_sout", sout_m, 1'b0);
    check1("abort_valid", sv_m, 1'b0);
    check1("abort_first", sf_m, 1'b0);
    check1("abort_busy", busy_m, 1'b0);
    run_frame(8'hFF, s_m, s_l);
    check32("ff_msb_stream", s_m, 32'hFF);
    end_of_frame("ff", 1'b0);

    // Randomized traffic; a pending word is held until the model says it was taken.
    hold = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rs = ($urandom_range(0, 99) == 0);
      en = ($urandom_range(0, 7) != 0);
      if (!hold) begin
        din_valid = ($urandom_range(0, 2) != 0);
        din       = W'($urandom);
      end
      hold = din_valid && !(en && !rs && (m_idx < 0 || m_idx == NB - 1));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
